// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared size encodings, responder FSM states and alignment check.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Only the two low address bits matter for natural alignment
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lsb);
        case (size)
            SZ_HALF: misaligned = addr_lsb[0];
            SZ_WORD: misaligned = (addr_lsb != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_sram_array.sv
`default_nettype none
// ============================================================================
// Module   : mem_sram_array
// Purpose  : Word-organised synchronous SRAM, byte write enables, registered read.
// Revision : 1.0 - initial release
// ============================================================================
module mem_sram_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    input  logic          i_re,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_be[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Data-port responder: wait states, alignment/range faults, lane
//            steering and load extension around an internal SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        fault,
    output logic        busy
);

    localparam int         AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] C_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t        r_state, w_next;
    logic [3:0]    r_cnt;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [1:0]    r_size;
    logic          r_uns, r_write, r_fault;
    logic [31:0]   r_rdata;

    logic          w_idle, w_accept, w_req_fault, w_commit;
    logic [AW+1:0] w_cur_addr;
    logic [31:0]   w_cur_wdata;
    logic [1:0]    w_cur_size;
    logic          w_cur_write, w_cur_fault;
    logic [3:0]    w_be;
    logic [31:0]   w_wword, w_dout, w_load;
    logic          w_re, w_load_done;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_accept    = w_idle && (mem_read || mem_write);
    assign w_req_fault = (mem_read && mem_write) || (size == 2'b11)
                       || misaligned(size, addr[1:0])
                       || ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));

    // With zero wait states the access commits on the accept edge itself, so
    // the live inputs stand in for the not-yet-latched request.
    assign w_cur_addr  = w_idle ? addr[AW+1:0] : r_addr;
    assign w_cur_wdata = w_idle ? wdata        : r_wdata;
    assign w_cur_size  = w_idle ? size         : r_size;
    assign w_cur_write = w_idle ? mem_write    : r_write;
    assign w_cur_fault = w_idle ? w_req_fault  : r_fault;
    assign w_commit    = !reset && (w_next == ST_RESP) && (r_state != ST_RESP);
    assign w_re        = w_commit && !w_cur_write && !w_cur_fault;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (mem_read || mem_write) w_next = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: if (r_cnt == 4'd0) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_write <= 1'b0;
            r_fault <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            if (w_accept) begin
                r_cnt   <= C_WAIT_LOAD;
                r_addr  <= addr[AW+1:0];
                r_wdata <= wdata;
                r_size  <= size;
                r_uns   <= load_unsigned;
                r_write <= mem_write;
                r_fault <= w_req_fault;
            end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_load_done) begin
                r_rdata <= w_load;
            end
        end
    end

    always_comb begin
        w_be    = 4'b0000;
        w_wword = w_cur_wdata;
        if (w_commit && w_cur_write && !w_cur_fault) begin
            case (w_cur_size)
                SZ_BYTE: begin
                    w_be    = 4'b0001 << w_cur_addr[1:0];
                    w_wword = {4{w_cur_wdata[7:0]}};
                end
                SZ_HALF: begin
                    w_be    = w_cur_addr[1] ? 4'b1100 : 4'b0011;
                    w_wword = {2{w_cur_wdata[15:0]}};
                end
                default: w_be = 4'b1111;
            endcase
        end
    end

    mem_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_sram (
        .clk     (clk),
        .i_be    (w_be),
        .i_addr  (w_cur_addr[AW+1:2]),
        .i_wdata (w_wword),
        .i_re    (w_re),
        .o_rdata (w_dout)
    );

    always_comb begin
        w_byte = w_dout[{r_addr[1:0], 3'b000} +: 8];
        w_half = r_addr[1] ? w_dout[31:16] : w_dout[15:0];
        case (r_size)
            SZ_BYTE: w_load = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: w_load = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = w_dout;
        endcase
    end

    // Load data is visible in the RESP cycle and held in r_rdata afterwards
    always_comb begin
        w_load_done = (r_state == ST_RESP) && !r_fault && !r_write;
        ready       = (r_state == ST_RESP);
        fault       = ready && r_fault;
        busy        = !w_idle;
        rdata       = w_load_done ? w_load : r_rdata;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the multicycle RISC-V core's data port. It accepts the `mem_read` / `mem_write` strobes the control unit raises in its MEM_RD / MEM_WR states, services them against an internal word-organised SRAM after a programmable number of wait states, and returns a one-cycle `ready` pulse with load data or a `fault` flag. Byte, halfword and word accesses are supported, with sign or zero extension on loads.

## Interface
- `DEPTH_WORDS`, 1024: SRAM depth in 32-bit words; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
- `WAIT_STATES`, 1: extra cycles between accept and completion; legal range 0..15.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `mem_read` in 1: load request strobe.
- `mem_write` in 1: store request strobe.
- `addr` in 32: byte address, sampled at accept.
- `wdata` in 32: store data, right-aligned; sampled at accept.
- `size` in 2: 00 byte, 01 halfword, 10 word; 11 is a fault.
- `load_unsigned` in 1: 1 zero-extends byte/half loads, 0 sign-extends.
- `rdata` out 32: extended load data; holds until the next successful load completes.
- `ready` out 1: one-cycle completion pulse.
- `fault` out 1: qualifies `ready`; high means no access was performed.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE: if `mem_read` or `mem_write` is sampled high, the request is accepted.
  - Latch `addr`, `wdata`, `size`, `load_unsigned` and the request kind.
  - Go to WAIT if WAIT_STATES>0, otherwise go to RESP.
- Strobes sampled in WAIT or RESP are ignored and not queued. The requester may hold a strobe as a level or pulse it for one cycle; either way it is treated as one request per IDLE acceptance.
- WAIT: a down-counter loaded with WAIT_STATES-1 at accept. Move to RESP when it reaches 0.
- Access is committed on the edge that enters RESP:
  - Write: byte-lane merge into the addressed word. Byte writes `wdata[7:0]` to lane `addr[1:0]`. Half writes `wdata[15:0]` to lanes {`addr[1]`,0}/+1. Word writes all lanes.
  - Read: select lane(s), extend to 32 bits, register into `rdata`.
- RESP: `ready`=1 for exactly one cycle, then return to IDLE. A new request can be accepted in the first IDLE cycle.
- A fault is raised and no SRAM or `rdata` update happens when any of these holds:
  - both strobes are high at accept;
  - `size`=11;
  - halfword with `addr[0]`=1;
  - word with `addr[1:0]`≠0;
  - word index ≥ DEPTH_WORDS.
- Faulted requests use the same latency as good ones. `fault` is high only in the RESP cycle.

## Timing
- Reset values: state IDLE, `ready`=0, `fault`=0, `busy`=0, `rdata`=0, wait counter 0. SRAM contents are not reset.
- Latency: accept edge E0, `ready` high in cycle E0+1+WAIT_STATES. With WAIT_STATES=0, `ready` is high in the cycle immediately after accept.
- Throughput: one request per 2+WAIT_STATES cycles.
- `busy` rises in the cycle after accept and falls in the cycle after RESP.
- Reset asserted in WAIT aborts the request: no write is committed and no `ready` is produced.
- Reset asserted in the RESP cycle clears `ready`/`fault` immediately. A write that has already been committed stays committed.
- A load returns the value of the most recent committed store to the same bytes. There is no forwarding hazard because only one request is outstanding.

## Structure
- Shared package `mem_pkg`:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - FSM state encoding;
  - a `misaligned(size, addr)` function, reused later by the core's trap logic.
- Sub-module `mem_sram_array`: DEPTH_WORDS×32 synchronous array with 4-bit byte write enable and registered read. The responder owns the FSM, the alignment/range checks, lane steering and extension.

## Test plan
- Word store then load, WAIT_STATES=1: store 0xDEADBEEF to 0x10, then load word from 0x10. `ready` comes 2 cycles after each accept, `rdata`=0xDEADBEEF, `fault`=0.
- Byte/half extension: with 0x80FF7F01 at 0x20:
  - lb 0x23 gives 0xFFFFFF80;
  - lbu 0x23 gives 0x00000080;
  - lh 0x22 gives 0xFFFF80FF;
  - lhu 0x20 gives 0x00007F01.
- Byte-lane store: sb 0xAA to 0x21 over 0x11223344. The word reads back 0x1122AA44.
- Faults, each giving `ready`+`fault` with memory and `rdata` unchanged:
  - sw to 0x02;
  - lh at 0x05;
  - `size`=11;
  - both strobes high;
  - address 4*DEPTH_WORDS.
- Latency sweep: WAIT_STATES=0 gives `ready` 1 cycle after accept, WAIT_STATES=3 gives 4 cycles. A strobe held high during `busy` yields exactly one `ready`.
- Reset mid-WAIT on sw 0x12345678 to 0x40: no `ready` is seen, and a following lw 0x40 returns the old value.
